// File: rtl/scpad_dram_req_arbiter.sv
// Arbitrates scratchpad DRAM read/write request queues into one registered request slot.
// Optional perf counters are enabled with `define SCPAD_ARB_PERF_EN.
module scpad_dram_req_arbiter #(
   parameter int unsigned DRAM_ADDR_WIDTH = 32,
   parameter int unsigned COL_IDX_WIDTH   = 6,
   parameter int unsigned DRAM_ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH      = 256,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned WR_BURST_MAX    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rd_valid,
   input  logic [DRAM_ADDR_WIDTH-1:0] rd_addr,
   input  logic [COL_IDX_WIDTH-1:0]   rd_num_bytes,
   input  logic [DRAM_ID_WIDTH-1:0]   rd_id,
   output logic                       rd_accepted,
   input  logic                       wr_valid,
   input  logic [DRAM_ADDR_WIDTH-1:0] wr_addr,
   input  logic [COL_IDX_WIDTH-1:0]   wr_num_bytes,
   input  logic [DRAM_ID_WIDTH-1:0]   wr_id,
   input  logic [DATA_WIDTH-1:0]      wr_wdata,
   input  logic                       wr_queue_full,
   output logic                       wr_accepted,
   input  logic                       dram_stall,
   input  logic                       dram_rd_done,
   output logic                       dram_req_valid,
   output logic                       dram_req_write,
   output logic [DRAM_ADDR_WIDTH-1:0] dram_req_addr,
   output logic [COL_IDX_WIDTH-1:0]   dram_req_num_bytes,
   output logic [DRAM_ID_WIDTH-1:0]   dram_req_id,
   output logic [DATA_WIDTH-1:0]      dram_req_wdata,
   output logic                       rd_credit_empty
`ifdef SCPAD_ARB_PERF_EN
   ,
   output logic [31:0]                perf_rd_issued,
   output logic [31:0]                perf_wr_issued,
   output logic [31:0]                perf_stall_cycles
`endif
);

   localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned BURST_W = $clog2(WR_BURST_MAX + 1);

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_DRAIN  = 1'b1
   } state_e;

   state_e                     state_q, state_d;
   logic                       last_wr_q, last_wr_d;
   logic [BURST_W-1:0]         burst_q, burst_d;

   logic [CNT_W-1:0]           outstanding_q, outstanding_d;
   logic                       credit_empty_q, credit_empty_d;

   logic                       slot_valid_q, slot_valid_d;
   logic                       slot_write_q, slot_write_d;
   logic [DRAM_ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
   logic [COL_IDX_WIDTH-1:0]   slot_nb_q, slot_nb_d;
   logic [DRAM_ID_WIDTH-1:0]   slot_id_q, slot_id_d;
   logic [DATA_WIDTH-1:0]      slot_wdata_q, slot_wdata_d;

   logic                       slot_drain;
   logic                       load_en;
   logic                       rd_drain;
   logic                       wr_drain;
   logic                       rd_elig;
   logic                       grant_rd;
   logic                       grant_wr;
   logic [CNT_W:0]             inflight;

   assign slot_drain = slot_valid_q & ~dram_stall;
   assign load_en    = ~slot_valid_q | slot_drain;
   assign rd_drain   = slot_drain & ~slot_write_q;
   assign wr_drain   = slot_drain & slot_write_q;

   // A read parked in the slot already owns a credit even though it has not drained yet.
   assign inflight = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, slot_valid_q & ~slot_write_q};
   assign rd_elig  = rd_valid && (inflight < (CNT_W+1)'(MAX_OUTSTANDING));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_NORMAL;
         last_wr_q <= 1'b1;
         burst_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         burst_q   <= burst_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      burst_d   = burst_q;
      if (grant_rd) last_wr_d = 1'b0;
      if (grant_wr) last_wr_d = 1'b1;
      case (state_q)
         ST_NORMAL: begin
            if (wr_queue_full && !grant_rd) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (grant_wr) burst_d = burst_q + BURST_W'(1);
            if ((burst_d == BURST_W'(WR_BURST_MAX)) || (!wr_valid && load_en)) begin
               state_d   = ST_NORMAL;
               burst_d   = '0;
               last_wr_d = 1'b1;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_comb begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (!rst && load_en) begin
         case (state_q)
            ST_NORMAL: begin
               if (rd_elig && wr_valid) begin
                  grant_rd = last_wr_q;
                  grant_wr = ~last_wr_q;
               end else begin
                  grant_rd = rd_elig;
                  grant_wr = wr_valid;
               end
            end
            ST_DRAIN: grant_wr = wr_valid;
            default: ;
         endcase
      end
   end

   assign rd_accepted = grant_rd;
   assign wr_accepted = grant_wr;

   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_write_d = slot_write_q;
      slot_addr_d  = slot_addr_q;
      slot_nb_d    = slot_nb_q;
      slot_id_d    = slot_id_q;
      slot_wdata_d = slot_wdata_q;
      if (slot_drain) slot_valid_d = 1'b0;
      if (grant_rd) begin
         slot_valid_d = 1'b1;
         slot_write_d = 1'b0;
         slot_addr_d  = rd_addr;
         slot_nb_d    = rd_num_bytes;
         slot_id_d    = rd_id;
         slot_wdata_d = '0;
      end else if (grant_wr) begin
         slot_valid_d = 1'b1;
         slot_write_d = 1'b1;
         slot_addr_d  = wr_addr;
         slot_nb_d    = wr_num_bytes;
         slot_id_d    = wr_id;
         slot_wdata_d = wr_wdata;
      end
   end

   // A retiring response and a newly issued read in the same cycle cancel out.
   always_comb begin
      outstanding_d = outstanding_q;
      if (rd_drain && !dram_rd_done) begin
         outstanding_d = outstanding_q + CNT_W'(1);
      end else if (!rd_drain && dram_rd_done && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - CNT_W'(1);
      end
      credit_empty_d = (outstanding_d == CNT_W'(MAX_OUTSTANDING));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid_q   <= 1'b0;
         slot_write_q   <= 1'b0;
         slot_addr_q    <= '0;
         slot_nb_q      <= '0;
         slot_id_q      <= '0;
         slot_wdata_q   <= '0;
         outstanding_q  <= '0;
         credit_empty_q <= 1'b0;
      end else begin
         slot_valid_q   <= slot_valid_d;
         slot_write_q   <= slot_write_d;
         slot_addr_q    <= slot_addr_d;
         slot_nb_q      <= slot_nb_d;
         slot_id_q      <= slot_id_d;
         slot_wdata_q   <= slot_wdata_d;
         outstanding_q  <= outstanding_d;
         credit_empty_q <= credit_empty_d;
      end
   end

   assign dram_req_valid     = slot_valid_q;
   assign dram_req_write     = slot_write_q;
   assign dram_req_addr      = slot_addr_q;
   assign dram_req_num_bytes = slot_nb_q;
   assign dram_req_id        = slot_id_q;
   assign dram_req_wdata     = slot_wdata_q;
   assign rd_credit_empty    = credit_empty_q;

`ifdef SCPAD_ARB_PERF_EN
   logic [2:0]  perf_inc;
   logic [31:0] perf_cnt_q [3];

   assign perf_inc[0] = rd_drain;
   assign perf_inc[1] = wr_drain;
   assign perf_inc[2] = slot_valid_q & dram_stall;

   // Counters saturate rather than wrap so long runs never report small values.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_perf
         always_ff @(posedge clk) begin
            if (rst) begin
               perf_cnt_q[gi] <= '0;
            end else if (perf_inc[gi] && !(&perf_cnt_q[gi])) begin
               perf_cnt_q[gi] <= perf_cnt_q[gi] + 32'd1;
            end
         end
      end
   endgenerate

   assign perf_rd_issued    = perf_cnt_q[0];
   assign perf_wr_issued    = perf_cnt_q[1];
   assign perf_stall_cycles = perf_cnt_q[2];
`else
   logic unused_wr_drain;
   assign unused_wr_drain = wr_drain;
`endif

endmodule

// File: tb/tb_scpad_dram_req_arbiter.sv
// Scoreboard bench for scpad_dram_req_arbiter: the bench plays both request queues and checks
// every issued request against a hand-ordered expectation queue.
module tb_scpad_dram_req_arbiter;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [5:0]   nb;
      logic [3:0]   id;
      logic [255:0] wdata;
   } req_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rd_valid = 1'b0;
   logic [31:0]  rd_addr = '0;
   logic [5:0]   rd_num_bytes = '0;
   logic [3:0]   rd_id = '0;
   logic         rd_accepted;
   logic         wr_valid = 1'b0;
   logic [31:0]  wr_addr = '0;
   logic [5:0]   wr_num_bytes = '0;
   logic [3:0]   wr_id = '0;
   logic [255:0] wr_wdata = '0;
   logic         wr_queue_full = 1'b0;
   logic         wr_accepted;
   logic         dram_stall = 1'b0;
   logic         dram_rd_done = 1'b0;
   logic         dram_req_valid;
   logic         dram_req_write;
   logic [31:0]  dram_req_addr;
   logic [5:0]   dram_req_num_bytes;
   logic [3:0]   dram_req_id;
   logic [255:0] dram_req_wdata;
   logic         rd_credit_empty;
`ifdef SCPAD_ARB_PERF_EN
   logic [31:0]  perf_rd_issued;
   logic [31:0]  perf_wr_issued;
   logic [31:0]  perf_stall_cycles;
`endif

   scpad_dram_req_arbiter dut (
      .clk                (clk),
      .rst                (rst),
      .rd_valid           (rd_valid),
      .rd_addr            (rd_addr),
      .rd_num_bytes       (rd_num_bytes),
      .rd_id              (rd_id),
      .rd_accepted        (rd_accepted),
      .wr_valid           (wr_valid),
      .wr_addr            (wr_addr),
      .wr_num_bytes       (wr_num_bytes),
      .wr_id              (wr_id),
      .wr_wdata           (wr_wdata),
      .wr_queue_full      (wr_queue_full),
      .wr_accepted        (wr_accepted),
      .dram_stall         (dram_stall),
      .dram_rd_done       (dram_rd_done),
      .dram_req_valid     (dram_req_valid),
      .dram_req_write     (dram_req_write),
      .dram_req_addr      (dram_req_addr),
      .dram_req_num_bytes (dram_req_num_bytes),
      .dram_req_id        (dram_req_id),
      .dram_req_wdata     (dram_req_wdata),
      .rd_credit_empty    (rd_credit_empty)
`ifdef SCPAD_ARB_PERF_EN
      ,
      .perf_rd_issued     (perf_rd_issued),
      .perf_wr_issued     (perf_wr_issued),
      .perf_stall_cycles  (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   req_t rdq[$];
   req_t wrq[$];
   req_t expq[$];
   req_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   seq = 0;
   bit   en_rd = 1'b0;
   bit   en_wr = 1'b0;
   logic acc_rd = 1'b0;
   logic acc_wr = 1'b0;

   task automatic mk_rd(input int n);
      req_t r;
      for (int i = 0; i < n; i++) begin
         r.wr    = 1'b0;
         r.addr  = 32'h1000 + 32'(seq) * 32'h40;
         r.nb    = 6'(seq + 1);
         r.id    = 4'(seq);
         r.wdata = '0;
         rdq.push_back(r);
         seq++;
      end
   endtask

   task automatic mk_wr(input int n);
      req_t r;
      for (int i = 0; i < n; i++) begin
         r.wr    = 1'b1;
         r.addr  = 32'h8000 + 32'(seq) * 32'h40;
         r.nb    = 6'(seq + 3);
         r.id    = 4'(seq + 7);
         r.wdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
         wrq.push_back(r);
         seq++;
      end
   endtask

   // One clock: present queue heads, record pops, advance to the next falling edge.
   task automatic cyc();
      rd_valid = en_rd && (rdq.size() > 0);
      wr_valid = en_wr && (wrq.size() > 0);
      if (rdq.size() > 0) begin
         rd_addr = rdq[0].addr; rd_num_bytes = rdq[0].nb; rd_id = rdq[0].id;
      end else begin
         rd_addr = '0; rd_num_bytes = '0; rd_id = '0;
      end
      if (wrq.size() > 0) begin
         wr_addr = wrq[0].addr; wr_num_bytes = wrq[0].nb; wr_id = wrq[0].id;
         wr_wdata = wrq[0].wdata;
      end else begin
         wr_addr = '0; wr_num_bytes = '0; wr_id = '0; wr_wdata = '0;
      end
      #1;
      acc_rd = rd_accepted;
      acc_wr = wr_accepted;
      @(negedge clk);
      if (acc_rd && rdq.size() > 0) rdq.delete(0);
      if (acc_wr && wrq.size() > 0) wrq.delete(0);
   endtask

   task automatic do_reset();
      rst = 1'b1; en_rd = 1'b0; en_wr = 1'b0;
      dram_stall = 1'b0; dram_rd_done = 1'b0; wr_queue_full = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      rdq.delete(); wrq.delete(); expq.delete();
      seq = 0;
   endtask

   // Scoreboard: every request leaving the slot must match the next expected entry.
   always begin
      @(negedge clk);
      #1;
      if (!rst && dram_req_valid && !dram_stall) begin
         total++;
         if (expq.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got wr=%0b addr=%h id=%0d, required no request",
                     dram_req_write, dram_req_addr, dram_req_id);
         end else begin
            mon_e = expq.pop_front();
            $display("issue %s addr=%h nb=%0d id=%0d", dram_req_write ? "WR" : "RD",
                     dram_req_addr, dram_req_num_bytes, dram_req_id);
            if ({dram_req_write, dram_req_addr, dram_req_num_bytes, dram_req_id, dram_req_wdata}
                !== {mon_e.wr, mon_e.addr, mon_e.nb, mon_e.id, mon_e.wdata}) begin
               bad++;
               $display("FAIL sb_req got wr=%0b addr=%h nb=%0d id=%0d wdata=%h required wr=%0b addr=%h nb=%0d id=%0d wdata=%h",
                        dram_req_write, dram_req_addr, dram_req_num_bytes, dram_req_id, dram_req_wdata,
                        mon_e.wr, mon_e.addr, mon_e.nb, mon_e.id, mon_e.wdata);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      mk_rd(1); mk_wr(1);
      en_rd = 1'b1; en_wr = 1'b1;
      cyc();
      cyc();
      total++;
      if ({acc_rd, acc_wr} !== 2'b00) begin
         bad++; $display("FAIL reset_accept got %b required 00", {acc_rd, acc_wr});
      end
      total++;
      if ({dram_req_valid, dram_req_write, dram_req_addr, dram_req_num_bytes, dram_req_id,
           dram_req_wdata, rd_credit_empty} !== '0) begin
         bad++; $display("FAIL reset_outputs got valid=%0b addr=%h credit_empty=%0b required all 0",
                         dram_req_valid, dram_req_addr, rd_credit_empty);
      end
      rst = 1'b0;
      expq.push_back(rdq[0]);
      expq.push_back(wrq[0]);
      cyc();
      total++;
      if ({acc_rd, acc_wr} !== 2'b10) begin
         bad++; $display("FAIL reset_first_tie got %b required 10", {acc_rd, acc_wr});
      end
      for (int i = 0; i < 10 && expq.size() != 0; i++) cyc();
      total++;
      if (expq.size() != 0) begin
         bad++; $display("FAIL reset_drain got %0d pending required 0", expq.size());
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      mk_rd(4); mk_wr(4);
      for (int k = 0; k < 4; k++) begin
         expq.push_back(rdq[k]);
         expq.push_back(wrq[k]);
      end
      en_rd = 1'b1; en_wr = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cyc();
         total++;
         if ({acc_rd, acc_wr} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr_grant cycle %0d got %b required %b", k, {acc_rd, acc_wr},
                            (k % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (k == 0) begin
            total++;
            if (dram_req_valid !== 1'b1) begin
               bad++; $display("FAIL rr_latency got valid=%0b required 1", dram_req_valid);
            end
         end
      end
      for (int i = 0; i < 10 && expq.size() != 0; i++) cyc();
      total++;
      if (expq.size() != 0) begin
         bad++; $display("FAIL rr_drain got %0d pending required 0", expq.size());
      end
   endtask

   task automatic test_stall_hold();
      req_t r0, r1;
      do_reset();
      mk_rd(2);
      r0 = rdq[0]; r1 = rdq[1];
      expq.push_back(r0); expq.push_back(r1);
      en_rd = 1'b1;
      cyc();
      dram_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         total++;
         if ({acc_rd, acc_wr} !== 2'b00) begin
            bad++; $display("FAIL stall_accept cycle %0d got %b required 00", k, {acc_rd, acc_wr});
         end
         total++;
         if ({dram_req_valid, dram_req_write, dram_req_addr, dram_req_num_bytes, dram_req_id, dram_req_wdata}
             !== {1'b1, 1'b0, 32'h1000, r0.nb, r0.id, 256'h0}) begin
            bad++; $display("FAIL stall_hold cycle %0d got valid=%0b addr=%h id=%0d required valid=1 addr=00001000 id=%0d",
                            k, dram_req_valid, dram_req_addr, dram_req_id, r0.id);
         end
      end
      dram_stall = 1'b0;
      cyc();
      total++;
      if (acc_rd !== 1'b1) begin
         bad++; $display("FAIL stall_release_accept got %b required 1", acc_rd);
      end
      total++;
      if ({dram_req_valid, dram_req_addr} !== {1'b1, r1.addr}) begin
         bad++; $display("FAIL stall_next_head got valid=%0b addr=%h required valid=1 addr=%h",
                         dram_req_valid, dram_req_addr, r1.addr);
      end
      for (int i = 0; i < 10 && expq.size() != 0; i++) cyc();
      total++;
      if (expq.size() != 0) begin
         bad++; $display("FAIL stall_drain got %0d pending required 0", expq.size());
      end
   endtask

   task automatic test_credits();
      int n;
      do_reset();
      dram_rd_done = 1'b1;
      cyc();
      cyc();
      dram_rd_done = 1'b0;
      mk_rd(10);
      for (int k = 0; k < 10; k++) expq.push_back(rdq[k]);
      en_rd = 1'b1;
      n = 0;
      for (int k = 0; k < 14; k++) begin
         cyc();
         n += int'(acc_rd);
      end
      total++;
      if (n != 8) begin
         bad++; $display("FAIL credit_limit got %0d reads accepted required 8", n);
      end
      total++;
      if (rd_credit_empty !== 1'b1) begin
         bad++; $display("FAIL credit_empty_set got %0b required 1", rd_credit_empty);
      end
      dram_rd_done = 1'b1;
      cyc();
      dram_rd_done = 1'b0;
      total++;
      if (rd_credit_empty !== 1'b0) begin
         bad++; $display("FAIL credit_empty_clear got %0b required 0", rd_credit_empty);
      end
      n = 0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         n += int'(acc_rd);
      end
      total++;
      if (n != 1) begin
         bad++; $display("FAIL credit_return got %0d reads accepted required 1", n);
      end
      total++;
      if ({rd_credit_empty, 32'(expq.size())} !== {1'b1, 32'd1}) begin
         bad++; $display("FAIL credit_final got empty=%0b pending=%0d required empty=1 pending=1",
                         rd_credit_empty, expq.size());
      end
   endtask

   task automatic test_drain();
      do_reset();
      mk_wr(6); mk_rd(3);
      for (int k = 0; k < 4; k++) expq.push_back(wrq[k]);
      expq.push_back(rdq[0]); expq.push_back(wrq[4]);
      expq.push_back(rdq[1]); expq.push_back(wrq[5]);
      expq.push_back(rdq[2]);
      wr_queue_full = 1'b1;
      cyc();
      wr_queue_full = 1'b0;
      en_rd = 1'b1; en_wr = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         total++;
         if ({acc_rd, acc_wr} !== ((k < 4) ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL drain_grant cycle %0d got %b required %b", k, {acc_rd, acc_wr},
                            (k < 4) ? 2'b01 : 2'b10);
         end
      end
      for (int i = 0; i < 12 && expq.size() != 0; i++) cyc();
      total++;
      if (expq.size() != 0) begin
         bad++; $display("FAIL drain_complete got %0d pending required 0", expq.size());
      end
      wr_queue_full = 1'b1;
      en_rd = 1'b0;
      cyc();
      wr_queue_full = 1'b0;
      mk_rd(1);
      expq.push_back(rdq[0]);
      en_rd = 1'b1;
      cyc();
      total++;
      if (acc_rd !== 1'b0) begin
         bad++; $display("FAIL drain_empty_exit got rd_accepted=%0b required 0", acc_rd);
      end
      cyc();
      total++;
      if (acc_rd !== 1'b1) begin
         bad++; $display("FAIL drain_after_exit got rd_accepted=%0b required 1", acc_rd);
      end
      for (int i = 0; i < 5 && expq.size() != 0; i++) cyc();
      total++;
      if (expq.size() != 0) begin
         bad++; $display("FAIL drain_tail got %0d pending required 0", expq.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mk_rd(4);
      for (int k = 0; k < 4; k++) expq.push_back(rdq[k]);
      en_rd = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      total++;
      if (dram_req_valid !== 1'b1) begin
         bad++; $display("FAIL midrst_setup got valid=%0b required 1", dram_req_valid);
      end
      rst = 1'b1;
      mk_rd(1); mk_wr(1);
      en_wr = 1'b1;
      cyc();
      total++;
      if ({acc_rd, acc_wr} !== 2'b00) begin
         bad++; $display("FAIL midrst_accept got %b required 00", {acc_rd, acc_wr});
      end
      rst = 1'b0;
      expq.delete();
      total++;
      if ({dram_req_valid, rd_credit_empty} !== 2'b00) begin
         bad++; $display("FAIL midrst_state got valid=%0b credit_empty=%0b required 0 0",
                         dram_req_valid, rd_credit_empty);
      end
      expq.push_back(rdq[0]);
      expq.push_back(wrq[0]);
      cyc();
      total++;
      if ({acc_rd, acc_wr} !== 2'b10) begin
         bad++; $display("FAIL midrst_tie got %b required 10", {acc_rd, acc_wr});
      end
      for (int i = 0; i < 6 && expq.size() != 0; i++) cyc();
      total++;
      if (expq.size() != 0) begin
         bad++; $display("FAIL midrst_drain got %0d pending required 0", expq.size());
      end
   endtask

   task automatic test_done_coincident();
      int n;
      do_reset();
      mk_rd(6);
      for (int k = 0; k < 6; k++) expq.push_back(rdq[k]);
      en_rd = 1'b1;
      for (int k = 0; k < 6; k++) cyc();
      dram_rd_done = 1'b1;
      cyc();
      dram_rd_done = 1'b0;
      mk_rd(8);
      for (int k = 0; k < 8; k++) expq.push_back(rdq[k]);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         n += int'(acc_rd);
      end
      total++;
      if (n != 3) begin
         bad++; $display("FAIL coincident_credit got %0d further reads required 3", n);
      end
      total++;
      if (rd_credit_empty !== 1'b1) begin
         bad++; $display("FAIL coincident_empty got %0b required 1", rd_credit_empty);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_stall_hold();
      test_credits();
      test_drain();
      test_reset_mid();
      test_done_coincident();
      do_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
